// File: rtl/sha_msg_pad.sv
// sha_msg_pad: SHA-2 message padder for the compression core.
// Takes a byte-granular message stream, tracks the message bit length, and
// emits fully padded blocks (data, 0x80 marker, zero fill, big-endian length).
// BLOCK_W=512/LEN_W=64 serves SHA-224/256; BLOCK_W=1024/LEN_W=128 serves SHA-384/512.
//
// Ports:
//   clk, rst (async, active-high), en (clock enable), sync_rst (local sync reset)
//   data_in / data_in_nbytes / data_in_last / data_in_valid / data_in_ready
//       message beats; byte 0 sits in the MSB byte; nbytes is read on the last beat
//   data_out / data_out_first / data_out_last / data_out_valid / data_out_ready
//       padded blocks; first marks the IV-reload block, last marks the final block
module sha_msg_pad #(
  parameter int unsigned BLOCK_W = 512,
  parameter int unsigned LEN_W   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         sync_rst,
  input  logic [BLOCK_W-1:0]           data_in,
  input  logic [$clog2(BLOCK_W/8):0]   data_in_nbytes,
  input  logic                         data_in_last,
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  output logic [BLOCK_W-1:0]           data_out,
  output logic                         data_out_first,
  output logic                         data_out_last,
  output logic                         data_out_valid,
  input  logic                         data_out_ready
);

  localparam int unsigned BLOCK_B = BLOCK_W / 8;
  localparam int unsigned NB_W    = $clog2(BLOCK_B) + 1;
  localparam int unsigned LEN_B   = LEN_W / 8;
  // Largest last-beat byte count that still leaves room for marker + length.
  localparam int unsigned ONE_MAX = BLOCK_B - LEN_B - 1;

  typedef enum logic {
    S_DATA  = 1'b0,
    S_EXTRA = 1'b1
  } state_t;

  state_t               r_state,       w_state_nxt;
  logic [LEN_W-1:0]     r_len_cnt,     w_len_cnt_nxt;
  logic                 r_first_pend,  w_first_pend_nxt;
  logic                 r_marker_pend, w_marker_pend_nxt;
  logic [BLOCK_W-1:0]   r_data_out,    w_data_out_nxt;
  logic                 r_out_first,   w_out_first_nxt;
  logic                 r_out_last,    w_out_last_nxt;
  logic                 r_out_valid,   w_out_valid_nxt;

  logic                 w_out_free;
  logic                 w_in_ready;
  logic [NB_W-1:0]      w_n;
  logic [LEN_W-1:0]     w_len_sum;
  logic [BLOCK_W-1:0]   w_pad;
  logic [BLOCK_W-1:0]   w_marker_blk;

  assign data_out       = r_data_out;
  assign data_out_first = r_out_first;
  assign data_out_last  = r_out_last;
  assign data_out_valid = r_out_valid;

  // Output register can take a new block when empty or being drained this cycle.
  assign w_out_free    = !r_out_valid || data_out_ready;
  assign w_in_ready    = !rst && en && (r_state == S_DATA) && w_out_free;
  assign data_in_ready = w_in_ready;

  // Effective byte count: full block unless last, clamped to BLOCK_B.
  always_comb begin : eff_bytes
    w_n = NB_W'(BLOCK_B);
    if (data_in_last && (data_in_nbytes < NB_W'(BLOCK_B))) begin
      w_n = data_in_nbytes;
    end
  end

  assign w_len_sum    = r_len_cnt + (LEN_W'(w_n) << 3);
  assign w_marker_blk = {8'h80, {(BLOCK_W-8){1'b0}}};

  // Keep bytes below n, place the 0x80 marker at byte n, zero everything else.
  always_comb begin : pad_build
    w_pad = '0;
    for (int unsigned i = 0; i < BLOCK_B; i++) begin
      if (NB_W'(i) < w_n) begin
        w_pad[BLOCK_W-1-8*i -: 8] = data_in[BLOCK_W-1-8*i -: 8];
      end else if (NB_W'(i) == w_n) begin
        w_pad[BLOCK_W-1-8*i -: 8] = 8'h80;
      end
    end
  end

  // Next-state and output-register load logic.
  always_comb begin : next_state
    w_state_nxt       = r_state;
    w_len_cnt_nxt     = r_len_cnt;
    w_first_pend_nxt  = r_first_pend;
    w_marker_pend_nxt = r_marker_pend;
    w_data_out_nxt    = r_data_out;
    w_out_first_nxt   = r_out_first;
    w_out_last_nxt    = r_out_last;
    w_out_valid_nxt   = r_out_valid;

    if (en) begin
      if (r_out_valid && data_out_ready) begin
        w_out_valid_nxt = 1'b0;
      end

      case (r_state)
        S_DATA: begin
          if (data_in_valid && w_in_ready) begin
            w_out_valid_nxt  = 1'b1;
            w_out_first_nxt  = r_first_pend;
            w_first_pend_nxt = 1'b0;
            if (!data_in_last) begin
              w_data_out_nxt = data_in;
              w_out_last_nxt = 1'b0;
              w_len_cnt_nxt  = w_len_sum;
            end else if (w_n <= NB_W'(ONE_MAX)) begin
              // Marker and length both fit: single closing block.
              w_data_out_nxt   = w_pad | BLOCK_W'(w_len_sum);
              w_out_last_nxt   = 1'b1;
              w_len_cnt_nxt    = '0;
              w_first_pend_nxt = 1'b1;
            end else if (w_n < NB_W'(BLOCK_B)) begin
              // Marker fits but length does not: length goes in an extra block.
              w_data_out_nxt    = w_pad;
              w_out_last_nxt    = 1'b0;
              w_len_cnt_nxt     = w_len_sum;
              w_marker_pend_nxt = 1'b0;
              w_state_nxt       = S_EXTRA;
            end else begin
              // Full block: both marker and length move to the extra block.
              w_data_out_nxt    = data_in;
              w_out_last_nxt    = 1'b0;
              w_len_cnt_nxt     = w_len_sum;
              w_marker_pend_nxt = 1'b1;
              w_state_nxt       = S_EXTRA;
            end
          end
        end

        S_EXTRA: begin
          if (w_out_free) begin
            w_data_out_nxt    = (r_marker_pend ? w_marker_blk : '0) | BLOCK_W'(r_len_cnt);
            w_out_first_nxt   = 1'b0;
            w_out_last_nxt    = 1'b1;
            w_out_valid_nxt   = 1'b1;
            w_len_cnt_nxt     = '0;
            w_first_pend_nxt  = 1'b1;
            w_marker_pend_nxt = 1'b0;
            w_state_nxt       = S_DATA;
          end
        end

        default: begin
          w_state_nxt = S_DATA;
        end
      endcase
    end
  end

  // State and output registers; sync_rst mirrors rst one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_DATA;
      r_len_cnt     <= '0;
      r_first_pend  <= 1'b1;
      r_marker_pend <= 1'b0;
      r_data_out    <= '0;
      r_out_first   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_valid   <= 1'b0;
    end else if (sync_rst) begin
      r_state       <= S_DATA;
      r_len_cnt     <= '0;
      r_first_pend  <= 1'b1;
      r_marker_pend <= 1'b0;
      r_data_out    <= '0;
      r_out_first   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_len_cnt     <= w_len_cnt_nxt;
      r_first_pend  <= w_first_pend_nxt;
      r_marker_pend <= w_marker_pend_nxt;
      r_data_out    <= w_data_out_nxt;
      r_out_first   <= w_out_first_nxt;
      r_out_last    <= w_out_last_nxt;
      r_out_valid   <= w_out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_sha_msg_pad.sv
// tb_sha_msg_pad: directed bench for sha_msg_pad (512-bit and 1024-bit instances).
module tb_sha_msg_pad;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 512-bit instance
  logic         rst;
  logic         en;
  logic         sync_rst;
  logic [511:0] data_in;
  logic [6:0]   data_in_nbytes;
  logic         data_in_last;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [511:0] data_out;
  logic         data_out_first;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready;

  // 1024-bit instance
  logic          k_en;
  logic          k_srst;
  logic [1023:0] k_data_in;
  logic [7:0]    k_nbytes;
  logic          k_last;
  logic          k_valid;
  logic          k_ready_in;
  logic [1023:0] k_data_out;
  logic          k_first_out;
  logic          k_last_out;
  logic          k_valid_out;
  logic          k_out_ready;

  sha_msg_pad #(.BLOCK_W(512), .LEN_W(64)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sync_rst(sync_rst),
    .data_in(data_in), .data_in_nbytes(data_in_nbytes), .data_in_last(data_in_last),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_first(data_out_first), .data_out_last(data_out_last),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  sha_msg_pad #(.BLOCK_W(1024), .LEN_W(128)) u_dut_k (
    .clk(clk), .rst(rst), .en(k_en), .sync_rst(k_srst),
    .data_in(k_data_in), .data_in_nbytes(k_nbytes), .data_in_last(k_last),
    .data_in_valid(k_valid), .data_in_ready(k_ready_in),
    .data_out(k_data_out), .data_out_first(k_first_out), .data_out_last(k_last_out),
    .data_out_valid(k_valid_out), .data_out_ready(k_out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit bp_mode  = 1'b0;
  logic [513:0] got_q[$];          // {first, last, data} per transferred block
  bit           stall_prev = 1'b0;
  logic [514:0] stall_saved;

  // Consumer: optional random backpressure/en, block capture, stall stability.
  always @(negedge clk) begin
    if (bp_mode) begin
      en = ($urandom_range(0, 3) != 0);
      data_out_ready = en && ($urandom_range(0, 1) == 1);
    end
    #1;
    if (stall_prev && !rst) begin
      n_checks++;
      if ({data_out_valid, data_out_first, data_out_last, data_out} !== stall_saved) begin
        n_fail++;
        $display("FAIL stall_hold got=%h exp=%h",
                 {data_out_valid, data_out_first, data_out_last, data_out}, stall_saved);
      end
    end
    if (data_out_valid && data_out_ready && en && !rst)
      got_q.push_back({data_out_first, data_out_last, data_out});
    stall_prev  = data_out_valid && !data_out_ready && !sync_rst && !rst;
    stall_saved = {data_out_valid, data_out_first, data_out_last, data_out};
  end

  // Drive one beat; must be called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input logic [511:0] d, input int nb, input bit last);
    int guard = 0;
    data_in        = d;
    data_in_nbytes = 7'(nb);
    data_in_last   = last;
    data_in_valid  = 1'b1;
    #1;
    while (!data_in_ready && guard < 300) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 300) begin
      n_fail++;
      $display("FAIL send_timeout got=not_accepted exp=accepted");
    end
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  // Wait (bounded) until n blocks have been captured.
  task automatic wait_blocks(input int n);
    int guard = 0;
    while (got_q.size() < n && guard < 600) begin
      @(negedge clk); #2; guard++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if ({data_out_valid, data_out_first, data_out_last, data_out} !== 515'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", {data_out_valid, data_out_first, data_out_last, data_out});
    end
    n_checks++;
    if ({k_valid_out, k_first_out, k_last_out, k_data_out} !== 1027'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_1k got_hi=%h exp=0", k_data_out[1023:768]);
    end
    n_checks++;
    if (data_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready got=%b exp=0", data_in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_checks++;
    if (data_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_in_ready got=%b exp=1", data_in_ready);
    end
  endtask

  task automatic test_abc();
    logic [513:0] exp_b;
    exp_b = {1'b1, 1'b1, 32'h61626380, 416'h0, 64'h18};
    got_q.delete();
    @(negedge clk);
    send_beat({24'h616263, {61{8'hFF}}}, 3, 1'b1);
    wait_blocks(1);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_b) begin
      n_fail++;
      $display("FAIL abc_block cnt=%0d got=%h exp=%h", got_q.size(), got_q[0], exp_b);
    end
  endtask

  task automatic test_56_bytes();
    logic [513:0] exp_b[2];
    exp_b[0] = {1'b1, 1'b0, {56{8'hA5}}, 8'h80, 56'h0};
    exp_b[1] = {1'b0, 1'b1, 448'h0, 64'h1C0};
    got_q.delete();
    @(negedge clk);
    send_beat({{56{8'hA5}}, {8{8'hFF}}}, 56, 1'b1);
    wait_blocks(2);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got_q[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL n56_blk%0d got=%h exp=%h", i, got_q[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_full_block();
    logic [513:0] exp_b[2];
    exp_b[0] = {1'b1, 1'b0, {64{8'h3C}}};
    exp_b[1] = {1'b0, 1'b1, 8'h80, 440'h0, 64'h200};
    got_q.delete();
    @(negedge clk);
    send_beat({64{8'h3C}}, 64, 1'b1);
    #2;
    n_checks++;
    if (got_q.size() != 1 || data_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL n64_latency cnt=%0d in_ready=%b exp cnt=1 in_ready=0", got_q.size(), data_in_ready);
    end
    @(negedge clk); #2;
    n_checks++;
    if (got_q.size() != 2) begin
      n_fail++;
      $display("FAIL n64_extra_no_bubble cnt=%0d exp=2", got_q.size());
    end
    wait_blocks(2);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got_q[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL n64_blk%0d got=%h exp=%h", i, got_q[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [513:0] exp_b[3];
    exp_b[0] = {1'b1, 1'b1, 8'h80, 504'h0};
    exp_b[1] = {1'b1, 1'b0, {64{8'h11}}};
    exp_b[2] = {1'b0, 1'b1, {10{8'h22}}, 8'h80, 360'h0, 64'h250};
    got_q.delete();
    @(negedge clk);
    send_beat({64{8'hFF}}, 0, 1'b1);
    send_beat({64{8'h11}}, 64, 1'b0);
    send_beat({{10{8'h22}}, {54{8'hFF}}}, 10, 1'b1);
    wait_blocks(3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_q[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL b2b_blk%0d got=%h exp=%h", i, got_q[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_1024();
    logic [1023:0] e1;
    logic [1023:0] e2;
    e1 = {{112{8'h9A}}, 8'h80, 120'h0};
    e2 = {896'h0, 128'h380};
    @(negedge clk);
    k_data_in = {{112{8'h9A}}, {16{8'hFF}}};
    k_nbytes  = 8'd112;
    k_last    = 1'b1;
    k_valid   = 1'b1;
    #1;
    n_checks++;
    if (k_ready_in !== 1'b1) begin
      n_fail++;
      $display("FAIL k1024_in_ready got=%b exp=1", k_ready_in);
    end
    @(negedge clk);
    k_valid = 1'b0;
    #1;
    n_checks++;
    if ({k_valid_out, k_first_out, k_last_out} !== 3'b110 || k_data_out !== e1) begin
      n_fail++;
      $display("FAIL k1024_blk0 vfl=%b exp=110 got_hi=%h exp_hi=%h got_lo=%h exp_lo=%h",
               {k_valid_out, k_first_out, k_last_out}, k_data_out[1023:768], e1[1023:768],
               k_data_out[255:0], e1[255:0]);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({k_valid_out, k_first_out, k_last_out} !== 3'b101 || k_data_out !== e2) begin
      n_fail++;
      $display("FAIL k1024_blk1 vfl=%b exp=101 got_hi=%h exp_hi=%h got_lo=%h exp_lo=%h",
               {k_valid_out, k_first_out, k_last_out}, k_data_out[1023:768], e2[1023:768],
               k_data_out[255:0], e2[255:0]);
    end
    @(negedge clk); #1;
    n_checks++;
    if (k_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL k1024_drained got=%b exp=0", k_valid_out);
    end
  endtask

  task automatic test_backpressure();
    logic [513:0] exp_b[7];
    exp_b[0] = {1'b1, 1'b0, {64{8'h01}}};
    exp_b[1] = {1'b0, 1'b0, {64{8'h02}}};
    exp_b[2] = {1'b0, 1'b0, {60{8'h03}}, 8'h80, 24'h0};
    exp_b[3] = {1'b0, 1'b1, 448'h0, 64'h5E0};
    exp_b[4] = {1'b1, 1'b1, 32'h61626380, 416'h0, 64'h18};
    exp_b[5] = {1'b1, 1'b0, {64{8'h4D}}};
    exp_b[6] = {1'b0, 1'b1, 8'h80, 440'h0, 64'h200};
    got_q.delete();
    @(negedge clk);
    bp_mode = 1'b1;
    send_beat({64{8'h01}}, 64, 1'b0);
    send_beat({64{8'h02}}, 64, 1'b0);
    send_beat({{60{8'h03}}, 32'hFFFF_FFFF}, 60, 1'b1);
    send_beat({24'h616263, {61{8'hFF}}}, 3, 1'b1);
    send_beat({64{8'h4D}}, 100, 1'b1);   // out-of-range count clamps to 64
    wait_blocks(7);
    bp_mode = 1'b0;
    en = 1'b1;
    data_out_ready = 1'b1;
    n_checks++;
    if (got_q.size() != 7) begin
      n_fail++;
      $display("FAIL bp_count got=%0d exp=7", got_q.size());
    end
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (got_q[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL bp_blk%0d got=%h exp=%h", i, got_q[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_sync_rst();
    logic [513:0] exp_b;
    exp_b = {1'b1, 1'b1, 32'h61626380, 416'h0, 64'h18};
    got_q.delete();
    @(negedge clk);
    data_out_ready = 1'b0;
    send_beat({64{8'h55}}, 64, 1'b0);
    sync_rst = 1'b1;
    #2;
    n_checks++;
    if ({data_out_valid, data_out_first, data_out_last} !== 3'b110) begin
      n_fail++;
      $display("FAIL srst_pre_vfl got=%b exp=110", {data_out_valid, data_out_first, data_out_last});
    end
    @(negedge clk);
    sync_rst = 1'b0;
    data_out_ready = 1'b1;
    #2;
    n_checks++;
    if (data_out_valid !== 1'b0 || data_out !== 512'd0 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL srst_cleared valid=%b cnt=%0d exp valid=0 cnt=0", data_out_valid, got_q.size());
    end
    @(negedge clk);
    send_beat({24'h616263, {61{8'hFF}}}, 3, 1'b1);
    wait_blocks(1);
    n_checks++;
    if (got_q[0] !== exp_b) begin
      n_fail++;
      $display("FAIL srst_restart got=%h exp=%h", got_q[0], exp_b);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sync_rst = 1'b0;
    data_in = '0; data_in_nbytes = '0; data_in_last = 1'b0; data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    k_en = 1'b1; k_srst = 1'b0; k_data_in = '0; k_nbytes = '0; k_last = 1'b0;
    k_valid = 1'b0; k_out_ready = 1'b1;

    test_reset();
    test_abc();
    test_56_bytes();
    test_full_block();
    test_back_to_back();
    test_1024();
    test_backpressure();
    test_sync_rst();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
